// File: rtl/bcd_seek_ctrl.sv
// Seek controller for a single-digit up/down BCD counter: walks the counter to a target
// digit along the shortest wrap-around path, verifying every step against the counter output.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | waiting for start
//  S_CALC  | validate operands, pick direction and step count
//  S_STEP  | one-cycle step pulse to the counter
//  S_WAIT  | settle gap, then check the counter moved exactly one digit
//  S_DONE  | one-cycle completion pulse
//  S_FAULT | sticky error, cleared only by a new start
module bcd_seek_ctrl #(
    parameter int unsigned STEP_GAP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] target,
    input  logic [3:0] cnt_in,
    output logic       step_out,
    output logic       updown_out,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    localparam int unsigned      GAP_W    = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(STEP_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_STEP,
        S_WAIT,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       tgt_r, tgt_nxt;
    logic [3:0]       cur_r, cur_nxt;
    logic [3:0]       steps_r, steps_nxt;
    logic             updown_r, updown_nxt;
    logic [GAP_W-1:0] gap_r, gap_nxt;
    logic [4:0]       dist_raw;
    logic [3:0]       up_dist;
    logic [3:0]       exp_val;

    // Upward distance modulo 10; only meaningful once both operands are known to be <= 9.
    always_comb begin
        dist_raw = {1'b0, tgt_r} + 5'd10 - {1'b0, cur_r};
        up_dist  = (dist_raw >= 5'd10) ? 4'(dist_raw - 5'd10) : dist_raw[3:0];
    end

    always_comb begin
        if (updown_r)
            exp_val = (cur_r == 4'd0) ? 4'd9 : cur_r - 4'd1;
        else
            exp_val = (cur_r == 4'd9) ? 4'd0 : cur_r + 4'd1;
    end

    always_comb begin
        state_nxt  = state;
        tgt_nxt    = tgt_r;
        cur_nxt    = cur_r;
        steps_nxt  = steps_r;
        updown_nxt = updown_r;
        gap_nxt    = gap_r;
        case (state)
            S_IDLE, S_FAULT: begin
                if (start) begin
                    tgt_nxt   = target;
                    cur_nxt   = cnt_in;
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (tgt_r > 4'd9 || cur_r > 4'd9) begin
                    state_nxt = S_FAULT;
                end else if (up_dist == 4'd0) begin
                    state_nxt = S_DONE;
                end else if (up_dist <= 4'd5) begin
                    updown_nxt = 1'b0;
                    steps_nxt  = up_dist;
                    state_nxt  = S_STEP;
                end else begin
                    updown_nxt = 1'b1;
                    steps_nxt  = 4'd10 - up_dist;
                    state_nxt  = S_STEP;
                end
            end
            S_STEP: begin
                gap_nxt   = GAP_LOAD;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (gap_r != '0) begin
                    gap_nxt = gap_r - GAP_W'(1);
                end else if (cnt_in == exp_val) begin
                    cur_nxt   = exp_val;
                    steps_nxt = steps_r - 4'd1;
                    state_nxt = (steps_r == 4'd1) ? S_DONE : S_STEP;
                end else begin
                    state_nxt = S_FAULT;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            tgt_r    <= '0;
            cur_r    <= '0;
            steps_r  <= '0;
            updown_r <= 1'b0;
            gap_r    <= '0;
        end else begin
            state    <= state_nxt;
            tgt_r    <= tgt_nxt;
            cur_r    <= cur_nxt;
            steps_r  <= steps_nxt;
            updown_r <= updown_nxt;
            gap_r    <= gap_nxt;
        end
    end

    assign step_out   = (state == S_STEP);
    assign updown_out = updown_r;
    assign busy       = (state == S_CALC) || (state == S_STEP) || (state == S_WAIT);
    assign done       = (state == S_DONE);
    assign fault      = (state == S_FAULT);

endmodule
